// File: rtl/s2p_receiver.sv
// Serial-to-parallel receiver for the seg7led link: oversamples sclk/sdin/sen/sclrn in the
// clk domain, rebuilds DATA_BITS-wide words and flags frames of the wrong length.
module s2p_receiver #(
  parameter int DATA_BITS = 16,
  parameter bit DIR       = 1'b0,
  localparam int CW       = $clog2(DATA_BITS + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 sdin,
  input  logic                 sen,
  input  logic                 sclrn,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [CW-1:0]        bit_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_BITS + 1);

  // Synchronizer bit order: {sclk, sen, sclrn, sdin}; idle levels 1,1,1,0.
  logic [3:0] s1_q;
  logic [3:0] s2_q;
  // Only the edge-detected pins need the third (delay) stage: {sclk, sen}.
  logic [1:0] s3_q;

  state_t                 state_q;
  logic [DATA_BITS-1:0]   sr_q;
  logic [CW-1:0]          cnt_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   err_q;
  logic                   busy_q;

  logic                   sclk_rise_s;
  logic                   sen_fall_s;
  logic                   sen_rise_s;
  logic                   sclrn_s;
  logic                   sdin_s;
  logic [DATA_BITS-1:0]   base_sr_s;
  logic [CW-1:0]          base_cnt_s;
  logic [DATA_BITS-1:0]   shifted_s;
  logic [DATA_BITS-1:0]   sr_d;
  logic [CW-1:0]          cnt_d;

  // Two-flop synchronizers plus the delay stage used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 4'b1110;
      s2_q <= 4'b1110;
      s3_q <= 2'b11;
    end else begin
      s1_q <= {sclk, sen, sclrn, sdin};
      s2_q <= s1_q;
      s3_q <= s2_q[3:2];
    end
  end

  assign sclk_rise_s = s2_q[3] & ~s3_q[1];
  assign sen_fall_s  = ~s2_q[2] & s3_q[0];
  assign sen_rise_s  = s2_q[2] & ~s3_q[0];
  assign sclrn_s     = s2_q[1];
  assign sdin_s      = s2_q[0];

  // Next shift register / bit count; a frame start begins from an empty register.
  always_comb begin
    base_sr_s  = sr_q;
    base_cnt_s = cnt_q;
    shifted_s  = sr_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    if (state_q == ST_IDLE) begin
      base_sr_s  = '0;
      base_cnt_s = '0;
    end else begin
      base_sr_s  = sr_q;
      base_cnt_s = cnt_q;
    end
    if (DIR == 1'b0) begin
      shifted_s = {base_sr_s[DATA_BITS-2:0], sdin_s};
    end else begin
      shifted_s = {sdin_s, base_sr_s[DATA_BITS-1:1]};
    end
    if (sclk_rise_s) begin
      sr_d  = shifted_s;
      cnt_d = (base_cnt_s == CNT_SAT) ? CNT_SAT : base_cnt_s + CW'(1);
    end else begin
      sr_d  = base_sr_s;
      cnt_d = base_cnt_s;
    end
  end

  // Frame FSM with registered outputs; a low sclrn level overrides every other event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (!sclrn_s) begin
        state_q <= ST_IDLE;
        sr_q    <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (sen_fall_s) begin
              state_q <= ST_SHIFT;
              sr_q    <= sr_d;
              cnt_q   <= cnt_d;
              busy_q  <= 1'b1;
            end else begin
              busy_q  <= 1'b0;
            end
          end
          ST_SHIFT: begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            if (sen_rise_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              if (cnt_d == CNT_FULL) begin
                data_q  <= sr_d;
                valid_q <= 1'b1;
              end else begin
                err_q   <= 1'b1;
              end
            end else begin
              busy_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = busy_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_s2p_receiver.sv
// Directed bench for s2p_receiver: an MSB-first and an LSB-first build share the same serial lines.
module tb_s2p_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, sdin, sen, sclrn;
  logic [15:0] data0, data1;
  logic        valid0, valid1, err0, err1, busy0, busy1;
  logic [4:0]  cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  int v0 = 0, e0 = 0, v1 = 0, e1 = 0, both0 = 0;
  int base_v0, base_e0, base_v1;
  logic pre_v, pre_e, at_v, at_e;

  always #5 clk = ~clk;

  s2p_receiver #(.DATA_BITS(16), .DIR(1'b0)) u_msb (
    .clk(clk), .rst(rst), .sclk(sclk), .sdin(sdin), .sen(sen), .sclrn(sclrn),
    .data(data0), .valid(valid0), .frame_err(err0), .busy(busy0), .bit_cnt(cnt0)
  );

  s2p_receiver #(.DATA_BITS(16), .DIR(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .sclk(sclk), .sdin(sdin), .sen(sen), .sclrn(sclrn),
    .data(data1), .valid(valid1), .frame_err(err1), .busy(busy1), .bit_cnt(cnt1)
  );

  always @(negedge clk) begin
    if (valid0) v0++;
    if (err0) e0++;
    if (valid1) v1++;
    if (err1) e1++;
    if (valid0 && err0) both0++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input bit lsb);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      sdin = lsb ? w[i] : w[n-1-i];
      tick(4);
      sclk = 1'b1;
      tick(4);
    end
  endtask

  task automatic start_frame();
    sen = 1'b0;
    tick(4);
  endtask

  task automatic start_on_bit(input logic b);
    sclk = 1'b0;
    sdin = b;
    tick(4);
    sen  = 1'b0;
    sclk = 1'b1;
    tick(4);
  endtask

  task automatic sample_end();
    tick(2);
    pre_v = valid0;
    pre_e = err0;
    tick(1);
    at_v = valid0;
    at_e = err0;
    tick(1);
  endtask

  task automatic end_frame();
    sen = 1'b1;
    sample_end();
  endtask

  task automatic end_on_bit(input logic b);
    sclk = 1'b0;
    sdin = b;
    tick(4);
    sclk = 1'b1;
    sen  = 1'b1;
    sample_end();
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b1; sdin = 1'b0; sen = 1'b1; sclrn = 1'b1;
    tick(3);
    chk("rst_data", data0, 16'h0000);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_err", err0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_cnt", cnt0, 5'd0);
    rst = 1'b0;
    tick(4);

    // T1: 0xA5C3 MSB first
    base_v0 = v0; base_e0 = e0;
    start_frame();
    send_bits(32'h0000A5C3, 16, 1'b0);
    chk("t1_busy", busy0, 1'b1);
    chk("t1_cnt", cnt0, 5'd16);
    end_frame();
    chk("t1_valid_early", pre_v, 1'b0);
    chk("t1_valid_lat3", at_v, 1'b1);
    chk("t1_data", data0, 16'hA5C3);
    chk("t1_data_lsb_build", data1, 16'hC3A5);
    chk("t1_vcount", v0 - base_v0, 1);
    chk("t1_ecount", e0 - base_e0, 0);
    chk("t1_busy_after", busy0, 1'b0);

    // T3: 15-bit frame
    base_v0 = v0; base_e0 = e0;
    start_frame();
    send_bits(32'h00007FFF, 15, 1'b0);
    end_frame();
    chk("t3_err_early", pre_e, 1'b0);
    chk("t3_err_lat3", at_e, 1'b1);
    chk("t3_no_valid", at_v, 1'b0);
    chk("t3_data_held", data0, 16'hA5C3);
    chk("t3_ecount", e0 - base_e0, 1);
    chk("t3_vcount", v0 - base_v0, 0);

    // T4: overlong frame, count saturates
    base_v0 = v0; base_e0 = e0;
    start_frame();
    send_bits(32'h0000AAAA, 16, 1'b0);
    chk("t4_cnt16", cnt0, 5'd16);
    send_bits(32'h00000001, 1, 1'b0);
    chk("t4_cnt17", cnt0, 5'd17);
    send_bits(32'h00000000, 1, 1'b0);
    chk("t4_cnt_sat", cnt0, 5'd17);
    chk("t4_busy", busy0, 1'b1);
    end_frame();
    chk("t4_err", at_e, 1'b1);
    chk("t4_ecount", e0 - base_e0, 1);
    chk("t4_vcount", v0 - base_v0, 0);
    chk("t4_data_held", data0, 16'hA5C3);

    // T2: 0x1234 LSB first
    base_v0 = v0; base_v1 = v1;
    start_frame();
    send_bits(32'h00001234, 16, 1'b1);
    end_frame();
    chk("t2_data_lsb_build", data1, 16'h1234);
    chk("t2_vcount_lsb_build", v1 - base_v1, 1);
    chk("t2_data_msb_build", data0, 16'h2C48);
    chk("t2_vcount_msb_build", v0 - base_v0, 1);

    // T5: sclrn abort, ignored idle clocks, then 0xFFFF
    base_v0 = v0; base_e0 = e0;
    start_frame();
    send_bits(32'h0000005A, 7, 1'b0);
    chk("t5_cnt7", cnt0, 5'd7);
    sclrn = 1'b0;
    tick(4);
    chk("t5_clr_cnt", cnt0, 5'd0);
    chk("t5_clr_busy", busy0, 1'b0);
    sen = 1'b1;
    tick(4);
    sclrn = 1'b1;
    tick(4);
    send_bits(32'h00000007, 3, 1'b0);
    chk("t5_idle_cnt", cnt0, 5'd0);
    chk("t5_idle_busy", busy0, 1'b0);
    chk("t5_no_pulses_v", v0 - base_v0, 0);
    chk("t5_no_pulses_e", e0 - base_e0, 0);
    chk("t5_data_held", data0, 16'h2C48);
    start_frame();
    send_bits(32'h0000FFFF, 16, 1'b0);
    end_frame();
    chk("t5_data", data0, 16'hFFFF);
    chk("t5_vcount", v0 - base_v0, 1);
    chk("t5_ecount", e0 - base_e0, 0);

    // T6: reset mid-frame, then back-to-back frames with coincident edges
    start_frame();
    send_bits(32'h00000015, 5, 1'b0);
    base_v0 = v0; base_e0 = e0;
    rst = 1'b1; sen = 1'b1; sclk = 1'b1;
    tick(4);
    chk("t6_rst_data", data0, 16'h0000);
    chk("t6_rst_busy", busy0, 1'b0);
    chk("t6_rst_cnt", cnt0, 5'd0);
    rst = 1'b0;
    tick(4);
    chk("t6_rst_no_valid", v0 - base_v0, 0);
    chk("t6_rst_no_err", e0 - base_e0, 0);
    start_on_bit(1'b0);
    send_bits(32'h00000001, 15, 1'b0);
    end_frame();
    chk("t6_frameA_data", data0, 16'h0001);
    chk("t6_frameA_valid", at_v, 1'b1);
    start_frame();
    send_bits(32'h00004000, 15, 1'b0);
    end_on_bit(1'b1);
    chk("t6_frameB_valid", at_v, 1'b1);
    chk("t6_frameB_data", data0, 16'h8001);
    chk("t6_vcount", v0 - base_v0, 2);
    chk("t6_ecount", e0 - base_e0, 0);
    chk("never_both", both0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
